// File: rtl/alu_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared definitions for the ALU share arbiter: FSM state encodings and
// requester port index constants.
// ---------------------------------------------------------------------------
package alu_share_arbiter_pkg;

    // FSM states; 2'b11 is never entered and is decoded as IDLE.
    typedef enum logic [1:0] {
        kSAIL_ALUARB_STATE_IDLE  = 2'b00,
        kSAIL_ALUARB_STATE_ISSUE = 2'b01,
        kSAIL_ALUARB_STATE_RESP  = 2'b10
    } alu_arb_state_e;

    // Requester indices
    localparam logic PORT_CORE = 1'b0;  // core pipeline side-path
    localparam logic PORT_AUX  = 1'b1;  // CSR / aux engine

    // Index -> one-hot conversion for the two-port grant
    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_pick.sv
// ---------------------------------------------------------------------------
// alu_arb_pick
// Stateless two-way picker. When exactly one port is valid it wins; when both
// are valid the port named by ptr wins.
// Ports:
//   req_valid [1:0] : per-port request valid
//   ptr             : preferred port on a tie
//   grant_oh  [1:0] : one-hot grant, zero when no port valid
//   grant_idx       : index of the granted port (meaningful when grant_oh!=0)
// ---------------------------------------------------------------------------
module alu_arb_pick
    import alu_share_arbiter_pkg::*;
(
    input  logic [1:0] req_valid,
    input  logic       ptr,
    output logic [1:0] grant_oh,
    output logic       grant_idx
);

    // Select winner and build one-hot grant
    always_comb begin
        grant_idx = PORT_CORE;
        grant_oh  = 2'b00;
        if (req_valid == 2'b11) begin
            grant_idx = ptr;
        end else begin
            grant_idx = req_valid[1];
        end
        if (|req_valid) begin
            grant_oh = port_onehot(grant_idx);
        end else begin
            grant_oh = 2'b00;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Time-shares one combinational ALU between two requesters. A request
// {ctl,a,b} is accepted in IDLE, presented to the ALU for one ISSUE cycle,
// and the captured {result,branch} is offered back in RESP until accepted.
//
// Build option: define ALU_ARB_ROUND_ROBIN_EN to break ties with a
// round-robin pointer (flipped to the other port on every accept). Without
// it, PRIO_HI always wins ties.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-port request handshake (2 bits)
//   req_ctl/req_a/req_b   : per-port packed ALUctl and operands
//   rsp_valid/rsp_ready   : per-port response handshake (2 bits)
//   rsp_result/rsp_branch : shared response data for the port in rsp_valid
//   alu_ctl/alu_a/alu_b/alu_enable : drive the shared ALU (zero unless ISSUE)
//   alu_out/alu_branch    : ALU results, captured at end of ISSUE
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CTL_W   = 7,
    parameter int PRIO_HI = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*CTL_W-1:0]   req_ctl,
    input  logic [2*XLEN-1:0]    req_a,
    input  logic [2*XLEN-1:0]    req_b,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [XLEN-1:0]      rsp_result,
    output logic                 rsp_branch,
    output logic [CTL_W-1:0]     alu_ctl,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic                 alu_enable,
    input  logic [XLEN-1:0]      alu_out,
    input  logic                 alu_branch
);

    localparam logic PRIO_BIT = (PRIO_HI != 0) ? 1'b1 : 1'b0;

    alu_arb_state_e   state_q,  state_d;
    logic [CTL_W-1:0] ctl_q,    ctl_d;
    logic [XLEN-1:0]  a_q,      a_d;
    logic [XLEN-1:0]  b_q,      b_d;
    logic             grant_q,  grant_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             branch_q, branch_d;

    logic [1:0]       pick_oh_s;
    logic             pick_idx_s;
    logic             pick_ptr_s;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic             rr_q, rr_d;

    // Tie-break pointer comes from the round-robin register
    always_comb begin
        pick_ptr_s = rr_q;
    end
`else
    // Tie-break pointer is fixed to the high-priority port
    always_comb begin
        pick_ptr_s = PRIO_BIT;
    end
`endif

    alu_arb_pick u_pick (
        .req_valid (req_valid),
        .ptr       (pick_ptr_s),
        .grant_oh  (pick_oh_s),
        .grant_idx (pick_idx_s)
    );

    // Next-state, latch updates and all block outputs
    always_comb begin
        state_d    = state_q;
        ctl_d      = ctl_q;
        a_d        = a_q;
        b_d        = b_q;
        grant_d    = grant_q;
        result_d   = result_q;
        branch_d   = branch_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        rr_d       = rr_q;
`endif
        req_ready  = 2'b00;
        rsp_valid  = 2'b00;
        alu_ctl    = {CTL_W{1'b0}};
        alu_a      = {XLEN{1'b0}};
        alu_b      = {XLEN{1'b0}};
        alu_enable = 1'b0;

        case (state_q)
            kSAIL_ALUARB_STATE_ISSUE: begin
                alu_ctl    = ctl_q;
                alu_a      = a_q;
                alu_b      = b_q;
                alu_enable = 1'b1;
                result_d   = alu_out;
                branch_d   = alu_branch;
                state_d    = kSAIL_ALUARB_STATE_RESP;
            end
            kSAIL_ALUARB_STATE_RESP: begin
                // Only the granted port's rsp_ready can release the response
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    state_d = kSAIL_ALUARB_STATE_IDLE;
                end else begin
                    state_d = kSAIL_ALUARB_STATE_RESP;
                end
            end
            default: begin
                // IDLE (and the unreachable 2'b11 encoding)
                // Reset suppresses acceptance so no handshake is reported
                // for a cycle whose state is about to be discarded.
                if (!rst && (|req_valid)) begin
                    req_ready = pick_oh_s;
                    grant_d   = pick_idx_s;
                    if (pick_idx_s) begin
                        ctl_d = req_ctl[CTL_W +: CTL_W];
                        a_d   = req_a[XLEN +: XLEN];
                        b_d   = req_b[XLEN +: XLEN];
                    end else begin
                        ctl_d = req_ctl[0 +: CTL_W];
                        a_d   = req_a[0 +: XLEN];
                        b_d   = req_b[0 +: XLEN];
                    end
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    rr_d    = ~pick_idx_s;
`endif
                    state_d = kSAIL_ALUARB_STATE_ISSUE;
                end else begin
                    state_d = kSAIL_ALUARB_STATE_IDLE;
                end
            end
        endcase
    end

    // Response data is driven straight from the capture registers
    always_comb begin
        rsp_result = result_q;
        rsp_branch = branch_q;
    end

    // State, operand latch, result latch and tie-break pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= kSAIL_ALUARB_STATE_IDLE;
            ctl_q    <= {CTL_W{1'b0}};
            a_q      <= {XLEN{1'b0}};
            b_q      <= {XLEN{1'b0}};
            grant_q  <= PRIO_BIT;
            result_q <= {XLEN{1'b0}};
            branch_q <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            rr_q     <= PRIO_BIT;
`endif
        end else begin
            state_q  <= state_d;
            ctl_q    <= ctl_d;
            a_q      <= a_d;
            b_q      <= b_d;
            grant_q  <= grant_d;
            result_q <= result_d;
            branch_q <= branch_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            rr_q     <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter with a small behavioural ALU attached
// to the alu_* ports. ALUctl encoding used by the bench ALU:
//   ctl[3:0] : 2=ADD, 6=SUB, 13=SRA
//   ctl[6:4] : 1=BEQ (branch when result==0), 2=BNE (branch when result!=0)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam int XLEN  = 32;
    localparam int CTL_W = 7;

    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd13;
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [2*CTL_W-1:0]   req_ctl;
    logic [2*XLEN-1:0]    req_a;
    logic [2*XLEN-1:0]    req_b;
    logic [1:0]           rsp_valid;
    logic [1:0]           rsp_ready;
    logic [XLEN-1:0]      rsp_result;
    logic                 rsp_branch;
    logic [CTL_W-1:0]     alu_ctl;
    logic [XLEN-1:0]      alu_a;
    logic [XLEN-1:0]      alu_b;
    logic                 alu_enable;
    logic [XLEN-1:0]      alu_out;
    logic                 alu_branch;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(XLEN), .CTL_W(CTL_W), .PRIO_HI(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctl(req_ctl), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_branch(rsp_branch),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_enable(alu_enable),
        .alu_out(alu_out), .alu_branch(alu_branch)
    );

    // Behavioural ALU: outputs zero when not enabled
    always_comb begin
        logic [XLEN-1:0] res;
        res        = 32'd0;
        alu_branch = 1'b0;
        if (alu_enable) begin
            case (alu_ctl[3:0])
                OP_ADD:  res = alu_a + alu_b;
                OP_SUB:  res = alu_a - alu_b;
                OP_SRA:  res = $signed(alu_a) >>> alu_b[4:0];
                default: res = 32'd0;
            endcase
            case (alu_ctl[6:4])
                BR_BEQ:  alu_branch = (res == 32'd0);
                BR_BNE:  alu_branch = (res != 32'd0);
                default: alu_branch = 1'b0;
            endcase
        end
        alu_out = res;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int port, input logic [2:0] br, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        req_ctl[port*CTL_W +: CTL_W] = {br, op};
        req_a[port*XLEN +: XLEN]     = a;
        req_b[port*XLEN +: XLEN]     = b;
        req_valid[port]              = 1'b1;
    endtask

    // One complete transaction with latency and ALU-isolation checks
    task automatic run_op(input string name, input int port, input logic [2:0] br,
                          input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_br);
        logic [1:0] exp_oh;
        exp_oh    = (port == 1) ? 2'b10 : 2'b01;
        rsp_ready = 2'b11;
        set_req(port, br, op, a, b);
        #1;
        n_cmp++;
        if (req_ready !== exp_oh) begin
            n_err++; $display("FAIL %s req_ready: got %b expected %b", name, req_ready, exp_oh);
        end
        n_cmp++;
        if (alu_enable !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            n_err++; $display("FAIL %s idle_isolation: en=%b a=%h b=%h expected 0", name, alu_enable, alu_a, alu_b);
        end
        tick();  // handshake edge -> ISSUE
        req_valid = 2'b00;
        req_a     = '1;  // operands may change after accept
        req_b     = '1;
        #1;
        n_cmp++;
        if (alu_enable !== 1'b1 || alu_a !== a || alu_b !== b || alu_ctl !== {br, op}) begin
            n_err++; $display("FAIL %s issue_drive: en=%b ctl=%h a=%h b=%h expected 1 %h %h %h",
                              name, alu_enable, alu_ctl, alu_a, alu_b, {br, op}, a, b);
        end
        n_cmp++;
        if (rsp_valid !== 2'b00) begin
            n_err++; $display("FAIL %s early_rsp: got %b expected 00", name, rsp_valid);
        end
        tick();  // -> RESP (two cycles after accept)
        n_cmp++;
        if (rsp_valid !== exp_oh) begin
            n_err++; $display("FAIL %s rsp_valid: got %b expected %b", name, rsp_valid, exp_oh);
        end
        n_cmp++;
        if (rsp_result !== exp_res || rsp_branch !== exp_br) begin
            n_err++; $display("FAIL %s result: got %h/%b expected %h/%b", name, rsp_result, rsp_branch, exp_res, exp_br);
        end
        n_cmp++;
        if (alu_enable !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctl !== 7'd0) begin
            n_err++; $display("FAIL %s resp_isolation: en=%b a=%h b=%h expected 0", name, alu_enable, alu_a, alu_b);
        end
        tick();  // accepted -> IDLE
        n_cmp++;
        if (rsp_valid !== 2'b00) begin
            n_err++; $display("FAIL %s rsp_drop: got %b expected 00", name, rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        req_ctl = '0; req_a = '0; req_b = '0;
        tick(); tick();
        n_cmp++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
            n_err++; $display("FAIL reset_handshake: rdy=%b vld=%b expected 00 00", req_ready, rsp_valid);
        end
        n_cmp++;
        if (rsp_result !== 32'd0 || rsp_branch !== 1'b0) begin
            n_err++; $display("FAIL reset_rsp: got %h/%b expected 0/0", rsp_result, rsp_branch);
        end
        n_cmp++;
        if (alu_enable !== 1'b0 || alu_ctl !== 7'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            n_err++; $display("FAIL reset_alu: en=%b ctl=%h a=%h b=%h expected 0", alu_enable, alu_ctl, alu_a, alu_b);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_op();
        run_op("add", 0, BR_NONE, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    endtask

    task automatic test_branch();
        run_op("beq", 1, BR_BEQ, OP_SUB, 32'h1234, 32'h1234, 32'd0, 1'b1);
        run_op("bne", 1, BR_BNE, OP_SUB, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_sra();
        run_op("sra", 0, BR_NONE, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    endtask

    task automatic test_back_pressure();
        rsp_ready = 2'b10;  // other port's ready must be ignored
        set_req(0, BR_NONE, OP_ADD, 32'd100, 32'd23);
        tick();  // handshake -> ISSUE
        req_valid = 2'b10;  // port 1 keeps asking during the stall
        tick();  // -> RESP
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (rsp_valid !== 2'b01 || rsp_result !== 32'd123 || req_ready !== 2'b00) begin
                n_err++; $display("FAIL bp_stall[%0d]: vld=%b res=%h rdy=%b expected 01 0000007b 00",
                                  i, rsp_valid, rsp_result, req_ready);
            end
            tick();
        end
        rsp_ready = 2'b01;
        tick();
        n_cmp++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            n_err++; $display("FAIL bp_release: vld=%b rdy=%b expected 00 10", rsp_valid, req_ready);
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 2'b11;
        set_req(1, BR_NONE, OP_ADD, 32'd40, 32'd2);
        tick();  // -> ISSUE
        req_valid = 2'b00;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (rsp_valid !== 2'b00 || alu_enable !== 1'b0 || alu_a !== 32'd0 || rsp_result !== 32'd0 || req_ready !== 2'b00) begin
            n_err++; $display("FAIL mid_reset: vld=%b en=%b a=%h res=%h rdy=%b expected all 0",
                              rsp_valid, alu_enable, alu_a, rsp_result, req_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 2'b00 || alu_enable !== 1'b0) begin
                n_err++; $display("FAIL mid_reset_quiet[%0d]: vld=%b en=%b expected 00 0", i, rsp_valid, alu_enable);
            end
        end
        run_op("post_reset", 1, BR_NONE, OP_ADD, 32'd40, 32'd2, 32'd42, 1'b0);
    endtask

    task automatic test_contention();
        logic [1:0]  exp_oh;
        logic [31:0] exp_res;
        int          waited;
        rst = 1'b1; tick(); rst = 1'b0;  // pointer back to reset value
        rsp_ready = 2'b11;
        set_req(0, BR_NONE, OP_ADD, 32'd1, 32'd1);
        set_req(1, BR_NONE, OP_ADD, 32'd3, 32'd4);
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_oh = 2'b01;
`endif
            exp_res = (exp_oh == 2'b01) ? 32'd2 : 32'd7;
            waited = 0;
            while (req_ready == 2'b00 && waited < 6) begin
                tick();
                waited++;
            end
            n_cmp++;
            if (req_ready !== exp_oh) begin
                n_err++; $display("FAIL contention_grant[%0d]: got %b expected %b", k, req_ready, exp_oh);
            end
            tick(); tick();  // ISSUE, RESP
            n_cmp++;
            if (rsp_valid !== exp_oh || rsp_result !== exp_res) begin
                n_err++; $display("FAIL contention_rsp[%0d]: vld=%b res=%h expected %b %h",
                                  k, rsp_valid, rsp_result, exp_oh, exp_res);
            end
            tick();  // -> IDLE
        end
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_branch();
        test_sra();
        test_back_pressure();
        test_reset_mid_op();
        test_contention();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
